// File: rtl/bram_prog_loader.sv
// Purpose : loads a length-prefixed little-endian word stream into the program BRAM and holds the CPU in reset until the load succeeds.
// Latency : one bram_we pulse the cycle after each 4th payload byte; done/error rise the cycle after the closing byte or header.
// Backpressure: s_ready is high for the whole load (header..CHK), so the stream can run at 1 byte/clk; s_valid gaps just stall.
//
// Ports:
//   ap_clk, ap_rst_n           clock, asynchronous active-low reset
//   load_req                   1-cycle pulse; starts a load from IDLE/DONE/ERROR
//   s_data/s_valid/s_ready     byte stream, transfer on s_valid & s_ready
//   bram_we/addr/wdata         full-word BRAM write port
//   cpu_rst                    active-high CPU reset, released only on success
//   busy/done/error/err_code   status (done/error sticky; err_code 1=length, 2=checksum)
//   words_loaded               words written by the current or last load
//
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module bram_prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int HDR_BYTES = 2
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              load_req,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   words_loaded
);

   if (HDR_BYTES != 2) begin : g_hdr_bad
      $error("bram_prog_loader: HDR_BYTES must be 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERROR
   } state_t;

   localparam int unsigned MAX_WORDS = 1 << ADDR_W;

   // State entered once the payload (or an empty header) has been consumed.
`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_POST = S_CHK;
`else
   localparam state_t S_POST = S_DONE;
`endif

   state_t            r_state, w_next;
   logic [7:0]        r_len_lo;
   logic [15:0]       r_len;
   logic [1:0]        r_lane;
   logic [23:0]       r_asm;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_cpu_rst, r_done, r_error;
   logic [1:0]        r_err_code;
   logic [ADDR_W:0]   r_words;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_chk;
`endif

   logic              w_acc, w_start, w_len_ovf, w_last_word;
   logic [15:0]       w_len;
   logic [ADDR_W:0]   w_words_inc;

   assign s_ready      = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CHK);
   assign busy         = s_ready;
   assign w_acc        = s_valid && s_ready;
   assign w_start      = load_req && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                      (r_state == S_ERROR));
   assign w_len        = {s_data, r_len_lo};
   assign w_len_ovf    = 32'(w_len) > MAX_WORDS;
   assign w_words_inc  = r_words + (ADDR_W+1)'(1);
   assign w_last_word  = (r_lane == 2'd3) && (32'(w_words_inc) == 32'(r_len));

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: if (load_req) w_next = S_LEN_LO;
         S_LEN_LO: if (w_acc) w_next = S_LEN_HI;
         S_LEN_HI: begin
            if (w_acc) begin
               if (w_len_ovf)          w_next = S_ERROR;
               else if (w_len == 16'd0) w_next = S_POST;
               else                    w_next = S_DATA;
            end
         end
         S_DATA: if (w_acc && w_last_word) w_next = S_POST;
`ifdef LOADER_CHECKSUM_EN
         S_CHK: if (w_acc) w_next = (s_data == r_chk) ? S_DONE : S_ERROR;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_len_lo   <= '0;
         r_len      <= '0;
         r_lane     <= '0;
         r_asm      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cpu_rst  <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= '0;
         r_words    <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_chk      <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         if (w_start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= '0;
            r_words    <= '0;
            r_lane     <= '0;
            r_cpu_rst  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_chk      <= '0;
`endif
         end
         if (w_acc) begin
            case (r_state)
               S_LEN_LO: r_len_lo <= s_data;
               S_LEN_HI: begin
                  r_len <= w_len;
                  if (w_len_ovf) r_err_code <= 2'd1;
               end
               S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                  r_chk <= r_chk ^ s_data;
`endif
                  r_lane <= r_lane + 2'd1;
                  case (r_lane)
                     2'd0: r_asm[7:0]   <= s_data;
                     2'd1: r_asm[15:8]  <= s_data;
                     2'd2: r_asm[23:16] <= s_data;
                     default: begin
                        // 4th byte completes the word; the write lands next cycle.
                        r_we    <= 1'b1;
                        r_addr  <= r_words[ADDR_W-1:0];
                        r_wdata <= {s_data, r_asm};
                        r_words <= w_words_inc;
                     end
                  endcase
               end
`ifdef LOADER_CHECKSUM_EN
               S_CHK: if (s_data != r_chk) r_err_code <= 2'd2;
`endif
               default: ;
            endcase
         end
         if ((w_next == S_DONE) && (r_state != S_DONE)) begin
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
         end
         if ((w_next == S_ERROR) && (r_state != S_ERROR)) r_error <= 1'b1;
      end
   end

   assign bram_we      = r_we;
   assign bram_addr    = r_addr;
   assign bram_wdata   = r_wdata;
   assign cpu_rst      = r_cpu_rst;
   assign done         = r_done;
   assign error        = r_error;
   assign err_code     = r_err_code;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_bram_prog_loader.sv
module tb_bram_prog_loader;
   localparam int ADDR_W = 10;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n = 1'b0;
   logic              load_req = 1'b0;
   logic [7:0]        s_data = 8'h00;
   logic              s_valid = 1'b0;
   logic              s_ready, bram_we, cpu_rst, busy, done, error;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_wdata;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   words_loaded;

   bram_prog_loader #(.ADDR_W(ADDR_W), .HDR_BYTES(2)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .load_req(load_req),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
      .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
      .err_code(err_code), .words_loaded(words_loaded)
   );

   always #5 ap_clk = ~ap_clk;

   // BRAM model and write-pulse counter
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   int we_cnt = 0;
   always @(posedge ap_clk) begin
      if (bram_we) begin
         mem[bram_addr] <= bram_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   typedef struct {
      string       name;
      logic [15:0] n;
      int          plen;
      logic [63:0] pl;       // byte i at [8i +: 8]
      logic        gaps;
      logic        chk_bad;
      logic        exp_done;
      logic        exp_err;
      logic [1:0]  exp_code;
      int          exp_words;
      logic [31:0] exp_w0;
      logic [31:0] exp_w1;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string nm, input logic [15:0] n, input int plen,
                          input logic [63:0] pl, input logic gaps, input logic bad,
                          input logic ed, input logic ee, input logic [1:0] ec,
                          input int ew, input logic [31:0] w0, input logic [31:0] w1);
      vec_t v;
      v.name = nm; v.n = n; v.plen = plen; v.pl = pl; v.gaps = gaps; v.chk_bad = bad;
      v.exp_done = ed; v.exp_err = ee; v.exp_code = ec; v.exp_words = ew;
      v.exp_w0 = w0; v.exp_w1 = w1;
      vecs.push_back(v);
   endtask

   function automatic logic [7:0] xor_bytes(input logic [63:0] pl, input int plen);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < plen; i++) x ^= pl[8*i +: 8];
      return x;
   endfunction

   task automatic pulse_load();
      load_req = 1'b1;
      @(posedge ap_clk); #1;
      load_req = 1'b0;
   endtask

   // Presents one byte, returns the cycles it took (1 when accepted immediately).
   task automatic send_byte(input logic [7:0] b, input logic gaps, inout int cyc);
      int t = 0;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         s_valid = 1'b0;
         @(posedge ap_clk); #1;
         cyc++;
      end
      s_data = b;
      s_valid = 1'b1;
      while (!s_ready && t < 50) begin
         @(posedge ap_clk); #1;
         t++;
      end
      if (!s_ready) begin
         check("ready_timeout", 32'(s_ready), 32'd1);
         s_valid = 1'b0;
         return;
      end
      @(posedge ap_clk); #1;
      cyc += t + 1;
      s_valid = 1'b0;
   endtask

   task automatic wait_end();
      for (int k = 0; k < 20 && !(done || error); k++) begin
         @(posedge ap_clk); #1;
      end
      @(posedge ap_clk); #1;
   endtask

   task automatic run_vec(input vec_t v);
      int base = we_cnt;
      int cyc = 0;
      int nbytes = 2;
      pulse_load();
      send_byte(v.n[7:0], v.gaps, cyc);
      send_byte(v.n[15:8], v.gaps, cyc);
      if (v.exp_code != 2'd1) begin
         for (int i = 0; i < v.plen; i++) begin
            send_byte(v.pl[8*i +: 8], v.gaps, cyc);
            nbytes++;
         end
`ifdef LOADER_CHECKSUM_EN
         send_byte(xor_bytes(v.pl, v.plen) ^ (v.chk_bad ? 8'h11 : 8'h00), v.gaps, cyc);
         nbytes++;
`endif
      end
      if (!v.gaps) check({v.name, ".cycles"}, 32'(cyc), 32'(nbytes));
      wait_end();
      check({v.name, ".done"},     32'(done),         32'(v.exp_done));
      check({v.name, ".error"},    32'(error),        32'(v.exp_err));
      check({v.name, ".err_code"}, 32'(err_code),     32'(v.exp_code));
      check({v.name, ".words"},    32'(words_loaded), 32'(v.exp_words));
      check({v.name, ".cpu_rst"},  32'(cpu_rst),      32'(!v.exp_done));
      check({v.name, ".busy"},     32'(busy),         32'd0);
      check({v.name, ".we_cnt"},   32'(we_cnt - base), 32'(v.exp_words));
      check({v.name, ".bram0"},    mem[0],            v.exp_w0);
      check({v.name, ".bram1"},    mem[1],            v.exp_w1);
   endtask

   initial begin
      int cyc;
      int base;
      vec_t fresh;

      // name, N, plen, payload, gaps, bad chk, done, err, code, words, bram0, bram1
      add_vec("golden",     16'd2,    8, 64'h0010_0093_0000_0513, 1'b0, 1'b0,
              1'b1, 1'b0, 2'd0, 2, 32'h0000_0513, 32'h0010_0093);
      add_vec("golden_gap", 16'd2,    8, 64'h0010_0093_0000_0513, 1'b1, 1'b0,
              1'b1, 1'b0, 2'd0, 2, 32'h0000_0513, 32'h0010_0093);
      add_vec("overflow",   16'h0401, 0, 64'h0,                   1'b0, 1'b0,
              1'b0, 1'b1, 2'd1, 0, 32'h0000_0513, 32'h0010_0093);
      add_vec("one_word",   16'd1,    4, 64'h0000_0000_1234_5678, 1'b0, 1'b0,
              1'b1, 1'b0, 2'd0, 1, 32'h1234_5678, 32'h0010_0093);
      add_vec("empty",      16'd0,    0, 64'h0,                   1'b0, 1'b0,
              1'b1, 1'b0, 2'd0, 0, 32'h1234_5678, 32'h0010_0093);
`ifdef LOADER_CHECKSUM_EN
      add_vec("chk_bad",    16'd1,    4, 64'h0000_0000_DDCC_BBAA, 1'b0, 1'b1,
              1'b0, 1'b1, 2'd2, 1, 32'hDDCC_BBAA, 32'h0010_0093);
      add_vec("chk_good",   16'd1,    4, 64'h0000_0000_DDCC_BBAA, 1'b0, 1'b0,
              1'b1, 1'b0, 2'd0, 1, 32'hDDCC_BBAA, 32'h0010_0093);
`endif

      // Reset state
      repeat (3) @(posedge ap_clk);
      #1;
      check("rst.cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst.s_ready", 32'(s_ready), 32'd0);
      check("rst.done",    32'(done),    32'd0);
      check("rst.busy",    32'(busy),    32'd0);
      check("rst.bram_we", 32'(bram_we), 32'd0);
      ap_rst_n = 1'b1;
      repeat (3) @(posedge ap_clk);
      #1;
      check("idle.cpu_rst", 32'(cpu_rst), 32'd1);
      check("idle.s_ready", 32'(s_ready), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // N = 1024 is the largest legal length: header must not be rejected.
      pulse_load();
      cyc = 0;
      send_byte(8'h00, 1'b0, cyc);
      send_byte(8'h04, 1'b0, cyc);
      check("n1024.error",   32'(error),   32'd0);
      check("n1024.busy",    32'(busy),    32'd1);
      check("n1024.s_ready", 32'(s_ready), 32'd1);
      ap_rst_n = 1'b0;
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      // Reset mid-load after 6 payload bytes of N = 3
      base = we_cnt;
      pulse_load();
      cyc = 0;
      send_byte(8'h03, 1'b0, cyc);
      send_byte(8'h00, 1'b0, cyc);
      for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0, cyc);
      ap_rst_n = 1'b0;
      #1;
      check("midrst.s_ready", 32'(s_ready),      32'd0);
      check("midrst.busy",    32'(busy),         32'd0);
      check("midrst.cpu_rst", 32'(cpu_rst),      32'd1);
      check("midrst.words",   32'(words_loaded), 32'd0);
      check("midrst.we",      32'(bram_we),      32'd0);
      check("midrst.addr",    32'(bram_addr),    32'd0);
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      s_data = 8'h55;
      s_valid = 1'b1;
      repeat (4) @(posedge ap_clk);
      #1;
      s_valid = 1'b0;
      check("midrst.idle_ready", 32'(s_ready),       32'd0);
      check("midrst.we_cnt",     32'(we_cnt - base), 32'd1);
      check("midrst.bram0",      mem[0],             32'h0403_0201);
      check("midrst.bram1",      mem[1],             32'h0010_0093);

      // Fresh load after reset, with a stray load_req mid-load that must be ignored
      fresh.pl = 64'h8877_6655_4433_2211;
      base = we_cnt;
      pulse_load();
      cyc = 0;
      send_byte(8'h02, 1'b0, cyc);
      send_byte(8'h00, 1'b0, cyc);
      for (int i = 0; i < 8; i++) begin
         load_req = (i == 2);
         send_byte(fresh.pl[8*i +: 8], 1'b0, cyc);
      end
      load_req = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      send_byte(xor_bytes(fresh.pl, 8), 1'b0, cyc);
`endif
      wait_end();
      check("fresh.done",    32'(done),          32'd1);
      check("fresh.cpu_rst", 32'(cpu_rst),       32'd0);
      check("fresh.words",   32'(words_loaded),  32'd2);
      check("fresh.we_cnt",  32'(we_cnt - base), 32'd2);
      check("fresh.bram0",   mem[0],             32'h4433_2211);
      check("fresh.bram1",   mem[1],             32'h8877_6655);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
